// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Same-cycle lookup for fetch; one resolved-branch update per cycle.
module branch_target_predictor #(
  parameter int unsigned ENTRIES      = 64,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [ADDR_WIDTH-1:0] lookupPc,
  output logic                  predictHit,
  output logic                  predictTaken,
  output logic [ADDR_WIDTH-1:0] predictTarget,
  input  logic                  updValid,
  input  logic [ADDR_WIDTH-1:0] updPc,
  input  logic                  updTaken,
  input  logic [ADDR_WIDTH-1:0] updTarget,
  input  logic                  flush
);

  localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

  localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_BITS-1:0] CNT_ZERO = '0;
  localparam logic [COUNTER_BITS-1:0] CNT_ONE  =
    COUNTER_BITS'(1);
  localparam logic [COUNTER_BITS-1:0] CNT_INIT =
    CNT_ONE << (COUNTER_BITS - 1);

  logic [ENTRIES-1:0]      valid_q;
  logic [TAG_BITS-1:0]     tag_q [ENTRIES];
  logic [ADDR_WIDTH-1:0]   tgt_q [ENTRIES];
  logic [COUNTER_BITS-1:0] cnt_q [ENTRIES];

  logic [INDEX_BITS-1:0]   lk_idx;
  logic [TAG_BITS-1:0]     lk_tag;
  logic [INDEX_BITS-1:0]   upd_idx;
  logic [TAG_BITS-1:0]     upd_tag;
  logic                    upd_hit;
  logic [COUNTER_BITS-1:0] cnt_cur;
  logic [COUNTER_BITS-1:0] cnt_d;
  logic                    wr_en;
  logic                    tgt_we;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{lookupPc[1:0], updPc[1:0]};

  assign lk_idx  = lookupPc[INDEX_BITS+1:2];
  assign lk_tag  = lookupPc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign upd_idx = updPc[INDEX_BITS+1:2];
  assign upd_tag = updPc[ADDR_WIDTH-1:INDEX_BITS+2];

  always_comb begin
    predictHit    = valid_q[lk_idx]
                  && (tag_q[lk_idx] == lk_tag);
    predictTaken  = predictHit
                  && cnt_q[lk_idx][COUNTER_BITS-1];
    predictTarget = lookupPc + ADDR_WIDTH'(4);
    if (predictTaken) begin
      predictTarget = tgt_q[lk_idx];
    end
  end

  // A not-taken miss leaves the entry alone so it cannot evict a live branch.
  always_comb begin
    upd_hit = valid_q[upd_idx]
            && (tag_q[upd_idx] == upd_tag);
    cnt_cur = cnt_q[upd_idx];
    cnt_d   = cnt_cur;
    wr_en   = updValid && !flush
            && (upd_hit || updTaken);
    tgt_we  = updTaken;
    if (!upd_hit) begin
      cnt_d = CNT_INIT;
    end else if (updTaken) begin
      if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + CNT_ONE;
    end else begin
      if (cnt_cur != CNT_ZERO) cnt_d = cnt_cur - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      cnt_q[upd_idx]   <= cnt_d;
      if (tgt_we) tgt_q[upd_idx] <= updTarget;
    end
  end

endmodule
